// File: rtl/data_sramlike_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_sramlike_slave_pkg
// Description : Shared types and helpers for the SRAM-like data slave:
//               FSM state enumeration, access size encodings, latched request
//               record and byte-strobe generation.
// Revision    : 1.0 - initial release
// ============================================================================
package data_sramlike_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Request attributes captured at the address handshake.
    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic [1:0] offset;
    } req_t;

    // Byte-lane write strobe for an access of the given size at the given
    // byte offset. Size 2'b11 falls through to a full-word access.
    function automatic logic [3:0] byte_strobe(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << offset;
            SIZE_HALF: strb = offset[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sramlike_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : data_sramlike_slave_if
// Description : SRAM-like data bus between a master and the data slave.
//   data_req      master -> slave  request valid
//   data_wr       master -> slave  1 = write, 0 = read
//   data_size     master -> slave  00 byte, 01 half, 10/11 word
//   data_addr     master -> slave  byte address
//   data_wdata    master -> slave  lane-aligned write data
//   data_rdata    slave  -> master read word
//   data_addr_ok  slave  -> master address handshake
//   data_data_ok  slave  -> master completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface data_sramlike_slave_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok
    );
endinterface
`default_nettype wire

// File: rtl/data_sramlike_slave_bank.sv
`default_nettype none
// ============================================================================
// Module      : sramlike_bank
// Description : DEPTH x 32-bit storage with per-byte write enables and a
//               registered synchronous read port. The read register only
//               loads when re_i is high, so it holds the last read word.
//   clk, rst   clock / synchronous active-high reset (read register only)
//   we_i       byte write enables
//   re_i       read enable (loads the read register)
//   addr_i     word index
//   wdata_i    write data
//   rdata_o    registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sramlike_bank #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [3:0]    we_i,
    input  wire logic          re_i,
    input  wire logic [AW-1:0] addr_i,
    input  wire logic [31:0]   wdata_i,
    output logic [31:0]        rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_sramlike_slave.sv
`default_nettype none
// ============================================================================
// Module      : data_sramlike_slave
// Description : Single-outstanding SRAM-like data slave with configurable
//               address-handshake delay and data latency.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        data_sramlike_slave_if.slave (request, handshakes, data)
//   DEPTH        memory size in 32-bit words (power of two)
//   ADDR_DELAY   extra request cycles before data_addr_ok (0..15)
//   DATA_LATENCY cycles from handshake to data_data_ok (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module data_sramlike_slave
    import data_sramlike_slave_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int ADDR_DELAY   = 0,
    parameter int DATA_LATENCY = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    data_sramlike_slave_if.slave  bus
);

    localparam int         AW           = $clog2(DEPTH);
    localparam logic [3:0] c_ADDR_DELAY = 4'(ADDR_DELAY);
    localparam logic [3:0] c_LAT_INIT   = 4'(DATA_LATENCY - 1);

    state_e          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    req_t            req_q, req_d;
    logic [AW-1:0]   idx_q, idx_d;

    logic            w_hs;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_we;
    logic            w_re;
    logic            w_unused;

    // Upper address bits are dropped, so addresses wrap modulo DEPTH words.
    assign w_idx = bus.data_addr[AW+1:2];

    assign w_hs = !rst && (state_q == IDLE) && bus.data_req
                  && (wait_cnt_q == c_ADDR_DELAY);

    // Writes commit and reads capture on the handshake edge itself.
    assign w_we = (w_hs && bus.data_wr)
                  ? byte_strobe(bus.data_size, bus.data_addr[1:0]) : 4'b0000;
    assign w_re = w_hs && !bus.data_wr;

    assign bus.data_addr_ok = w_hs;
    assign bus.data_data_ok = !rst && (state_q == RESP);

    // Latched request record is kept for observability only.
    assign w_unused = ^{bus.data_addr, req_q, idx_q};

    sramlike_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_we),
        .re_i    (w_re),
        .addr_i  (w_idx),
        .wdata_i (bus.data_wdata),
        .rdata_o (bus.data_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        req_d      = req_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                if (w_hs) begin
                    req_d.wr     = bus.data_wr;
                    req_d.size   = bus.data_size;
                    req_d.offset = bus.data_addr[1:0];
                    idx_d        = w_idx;
                    wait_cnt_d   = '0;
                    lat_cnt_d    = c_LAT_INIT;
                    // A latency of one leaves no countdown cycles, so the
                    // response cycle follows the handshake directly.
                    state_d      = (c_LAT_INIT == 4'd0) ? RESP : BUSY;
                end else if (bus.data_req) begin
                    if (wait_cnt_q < c_ADDR_DELAY) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            BUSY: begin
                // Leave when the decremented count reaches zero, giving
                // DATA_LATENCY-1 BUSY cycles between handshake and RESP.
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            req_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            req_q      <= req_d;
            idx_q      <= idx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sramlike_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sramlike_slave
// Description : Self-checking bench for data_sramlike_slave. Two instances:
//               A (DEPTH 1024, no address delay, latency 1) and
//               B (DEPTH 256, address delay 3, latency 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sramlike_slave;

    localparam int A_DEPTH = 1024, A_AD = 0, A_LAT = 1;
    localparam int B_DEPTH = 256,  B_AD = 3, B_LAT = 4;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   passed = 0;

    data_sramlike_slave_if ifa ();
    data_sramlike_slave_if ifb ();

    data_sramlike_slave #(.DEPTH(A_DEPTH), .ADDR_DELAY(A_AD), .DATA_LATENCY(A_LAT))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
    data_sramlike_slave #(.DEPTH(B_DEPTH), .ADDR_DELAY(B_AD), .DATA_LATENCY(B_LAT))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int ad_of(input int sel);  return (sel == 0) ? A_AD : B_AD;   endfunction
    function automatic int lat_of(input int sel); return (sel == 0) ? A_LAT : B_LAT; endfunction
    function automatic int aw_of(input int sel);  return (sel == 0) ? 10 : 8;        endfunction
    function automatic logic aok(input int sel);  return (sel == 0) ? ifa.data_addr_ok : ifb.data_addr_ok; endfunction
    function automatic logic dok(input int sel);  return (sel == 0) ? ifa.data_data_ok : ifb.data_data_ok; endfunction
    function automatic logic [31:0] rdat(input int sel); return (sel == 0) ? ifa.data_rdata : ifb.data_rdata; endfunction

    // Reference byte merge: a lane is written when it lies inside the
    // naturally aligned byte / halfword / word containing the address.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        logic        hit;
        r = old;
        for (int b = 0; b < 4; b++) begin
            case (size)
                2'b00:   hit = (b == int'(off));
                2'b01:   hit = ((b / 2) == int'(off[1]));
                default: hit = 1'b1;
            endcase
            if (hit) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic drive(input int sel, input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 0) begin
            ifa.data_req = req; ifa.data_wr = wr; ifa.data_size = size;
            ifa.data_addr = addr; ifa.data_wdata = wdata;
        end else begin
            ifb.data_req = req; ifb.data_wr = wr; ifb.data_size = size;
            ifb.data_addr = addr; ifb.data_wdata = wdata;
        end
    endtask

    task automatic drive_idle(input int sel);
        logic [31:0] r1, r2, r3;
        r1 = $urandom; r2 = $urandom; r3 = $urandom;
        drive(sel, 1'b0, r1[0], r1[2:1], r2, r3);
    endtask

    // Runs one transaction; reports request cycles to addr_ok, cycles from
    // the handshake to data_ok, number of data_ok pulses and rdata seen.
    task automatic do_txn(input int sel, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int hs_n, output int ok_n, output int pulses, output logic [31:0] rd);
        hs_n = -1; ok_n = -1; pulses = 0; rd = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk); drive(sel, 1'b1, wr, size, addr, wdata); #1;
            if (aok(sel)) begin hs_n = c; break; end
        end
        if (hs_n < 0) begin drive_idle(sel); return; end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk); drive_idle(sel); #1;
            if (dok(sel)) begin
                pulses++;
                if (ok_n < 0) begin ok_n = c; rd = rdat(sel); end
            end
            if (ok_n > 0 && c >= ok_n + 3) break;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (aok(0) !== 1'b0) $display("FAIL rst_aok_a got=%b exp=0", aok(0)); else passed++;
        checks++; if (dok(0) !== 1'b0) $display("FAIL rst_dok_a got=%b exp=0", dok(0)); else passed++;
        checks++; if (aok(1) !== 1'b0) $display("FAIL rst_aok_b got=%b exp=0", aok(1)); else passed++;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        drive_idle(0); drive_idle(1);
        #1;
        checks++; if (rdat(0) !== 32'h0) $display("FAIL rst_rdata_a got=%h exp=0", rdat(0)); else passed++;
        checks++; if (rdat(1) !== 32'h0) $display("FAIL rst_rdata_b got=%h exp=0", rdat(1)); else passed++;
    endtask

    task automatic test_word_rw();
        int h, o, p; logic [31:0] rd;
        do_txn(0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, h, o, p, rd);
        checks++; if (h !== 1 || o !== 1 || p !== 1) $display("FAIL wr_timing got=%0d/%0d/%0d exp=1/1/1", h, o, p); else passed++;
        do_txn(0, 1'b0, 2'b10, 32'h100, 32'h0, h, o, p, rd);
        checks++; if (h !== 1 || o !== 1 || p !== 1) $display("FAIL rd_timing got=%0d/%0d/%0d exp=1/1/1", h, o, p); else passed++;
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL word_rd got=%h exp=deadbeef", rd); else passed++;
    endtask

    task automatic test_byte_half();
        int h, o, p; logic [31:0] rd;
        do_txn(0, 1'b1, 2'b10, 32'h200, 32'h11223344, h, o, p, rd);
        do_txn(0, 1'b1, 2'b00, 32'h201, 32'h0000AB00, h, o, p, rd);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL wr_keeps_rdata got=%h exp=deadbeef", rd); else passed++;
        do_txn(0, 1'b0, 2'b10, 32'h200, 32'h0, h, o, p, rd);
        checks++; if (rd !== 32'h1122AB44) $display("FAIL byte_lane got=%h exp=1122ab44", rd); else passed++;
        do_txn(0, 1'b1, 2'b01, 32'h202, 32'hCDEF0000, h, o, p, rd);
        do_txn(0, 1'b0, 2'b10, 32'h200, 32'h0, h, o, p, rd);
        checks++; if (rd !== 32'hCDEFAB44) $display("FAIL half_lane got=%h exp=cdefab44", rd); else passed++;
    endtask

    task automatic test_alias();
        int h, o, p; logic [31:0] rd;
        do_txn(0, 1'b1, 2'b10, 32'h0, 32'h600DF00D, h, o, p, rd);
        do_txn(0, 1'b0, 2'b10, 32'(A_DEPTH * 4), 32'h0, h, o, p, rd);
        checks++; if (rd !== 32'h600DF00D) $display("FAIL alias_rd got=%h exp=600df00d", rd); else passed++;
        do_txn(0, 1'b1, 2'b10, 32'(A_DEPTH * 4), 32'h0BADCAFE, h, o, p, rd);
        do_txn(0, 1'b0, 2'b10, 32'h0, 32'h0, h, o, p, rd);
        checks++; if (rd !== 32'h0BADCAFE) $display("FAIL alias_wr got=%h exp=0badcafe", rd); else passed++;
    endtask

    // Request held continuously: each transaction takes AD+1 request cycles
    // plus LAT response cycles, and repeats with that period.
    task automatic test_held();
        int per;
        per = B_AD + 1 + B_LAT;
        for (int c = 1; c <= 3 * per; c++) begin
            @(negedge clk); drive(1, 1'b1, 1'b1, 2'b10, 32'h304, 32'hC0FFEE00); #1;
            checks++; if (aok(1) !== ((c % per) == B_AD + 1)) $display("FAIL held_aok c=%0d got=%b", c, aok(1)); else passed++;
            checks++; if (dok(1) !== ((c % per) == 0)) $display("FAIL held_dok c=%0d got=%b", c, dok(1)); else passed++;
        end
        repeat (4) begin @(negedge clk); drive_idle(1); end
    endtask

    task automatic test_drop();
        int h, o, p; logic [31:0] rd;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); drive(1, 1'b1, 1'b0, 2'b10, 32'h304, 32'h0); #1;
            checks++; if (aok(1) !== 1'b0) $display("FAIL drop_early_aok got=%b exp=0", aok(1)); else passed++;
        end
        @(negedge clk); drive_idle(1);
        do_txn(1, 1'b0, 2'b10, 32'h304, 32'h0, h, o, p, rd);
        checks++; if (h !== B_AD + 1) $display("FAIL drop_restart got=%0d exp=%0d", h, B_AD + 1); else passed++;
        checks++; if (o !== B_LAT || p !== 1) $display("FAIL b_latency got=%0d/%0d exp=%0d/1", o, p, B_LAT); else passed++;
        checks++; if (rd !== 32'hC0FFEE00) $display("FAIL b_rd got=%h exp=c0ffee00", rd); else passed++;
    endtask

    task automatic test_reset_mid();
        int h, o, p, hs, cnt; logic [31:0] rd;
        // Reset in BUSY after a write handshake.
        hs = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); drive(1, 1'b1, 1'b1, 2'b10, 32'h300, 32'h5A5A5A5A); #1;
            if (aok(1)) begin hs = c; break; end
        end
        checks++; if (hs !== B_AD + 1) $display("FAIL rm_hs got=%0d exp=%0d", hs, B_AD + 1); else passed++;
        @(negedge clk); drive_idle(1); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0; #1;
        checks++; if (rdat(1) !== 32'h0) $display("FAIL rm_rdata got=%h exp=0", rdat(1)); else passed++;
        cnt = 0;
        repeat (8) begin @(negedge clk); drive_idle(1); #1; if (dok(1)) cnt++; end
        checks++; if (cnt !== 0) $display("FAIL rm_busy_dok got=%0d exp=0", cnt); else passed++;
        do_txn(1, 1'b0, 2'b10, 32'h300, 32'h0, h, o, p, rd);
        checks++; if (rd !== 32'h5A5A5A5A) $display("FAIL rm_mem got=%h exp=5a5a5a5a", rd); else passed++;
        // Reset landing on the response cycle.
        hs = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); drive(1, 1'b1, 1'b1, 2'b10, 32'h308, 32'h0F0F0F0F); #1;
            if (aok(1)) begin hs = c; break; end
        end
        for (int c = 1; c <= B_LAT; c++) begin
            @(negedge clk); drive_idle(1);
            if (c == B_LAT) rst_b = 1'b1;
            #1;
            if (c == B_LAT) begin
                checks++; if (dok(1) !== 1'b0) $display("FAIL rm_resp_dok got=%b exp=0", dok(1)); else passed++;
            end
        end
        @(negedge clk); rst_b = 1'b0;
        cnt = 0;
        repeat (6) begin @(negedge clk); drive_idle(1); #1; if (dok(1)) cnt++; end
        checks++; if (cnt !== 0) $display("FAIL rm_resp_late got=%0d exp=0", cnt); else passed++;
        do_txn(1, 1'b0, 2'b10, 32'h308, 32'h0, h, o, p, rd);
        checks++; if (rd !== 32'h0F0F0F0F) $display("FAIL rm_mem2 got=%h exp=0f0f0f0f", rd); else passed++;
    endtask

    task automatic test_random(input int sel);
        logic [31:0] w [16];
        logic [31:0] last, exp, addr, wd, upper, rd;
        logic [1:0]  size, off;
        logic        wr;
        int          base, idx, h, o, p;
        base = (sel == 0) ? 32'h80 : 32'h20;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            do_txn(sel, 1'b1, 2'b10, 32'((base + i) << 2), wd, h, o, p, rd);
            w[i] = wd;
            checks++; if (h !== ad_of(sel) + 1 || o !== lat_of(sel)) $display("FAIL rnd_init_timing sel=%0d got=%0d/%0d", sel, h, o); else passed++;
        end
        do_txn(sel, 1'b0, 2'b10, 32'(base << 2), 32'h0, h, o, p, rd);
        checks++; if (rd !== w[0]) $display("FAIL rnd_first sel=%0d got=%h exp=%h", sel, rd, w[0]); else passed++;
        last = w[0];
        for (int n = 0; n < 40; n++) begin
            idx   = $urandom_range(0, 15);
            off   = 2'($urandom_range(0, 3));
            size  = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            upper = $urandom;
            wd    = $urandom;
            addr  = (upper << (aw_of(sel) + 2)) | 32'((base + idx) << 2) | {30'h0, off};
            do_txn(sel, wr, size, addr, wd, h, o, p, rd);
            if (wr) begin
                w[idx] = merge(w[idx], wd, size, off);
                exp = last;
            end else begin
                exp = w[idx];
            end
            last = exp;
            checks++; if (h !== ad_of(sel) + 1) $display("FAIL rnd_hs sel=%0d n=%0d got=%0d exp=%0d", sel, n, h, ad_of(sel) + 1); else passed++;
            checks++; if (o !== lat_of(sel) || p !== 1) $display("FAIL rnd_ok sel=%0d n=%0d got=%0d/%0d exp=%0d/1", sel, n, o, p, lat_of(sel)); else passed++;
            checks++; if (rd !== exp) $display("FAIL rnd_data sel=%0d n=%0d wr=%b size=%0d addr=%h got=%h exp=%h", sel, n, wr, size, addr, rd, exp); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_alias();
        test_held();
        test_drop();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_sramlike_slave.md
DATA_SRAMLIKE_SLAVE -- requirements
Module: data_sramlike_slave

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the memory size in 32-bit words; it is a power of two and AW = log2(DEPTH).
REQ-002 Parameter ADDR_DELAY, default 0, range 0..15, SHALL set how many extra cycles data_req is held before data_addr_ok.
REQ-003 Parameter DATA_LATENCY, default 1, range 1..15, SHALL set the number of cycles from the address handshake to data_data_ok.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-006 Port data_req, input, 1 bit: master request valid.
REQ-007 Port data_wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port data_size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
REQ-009 Port data_addr, input, 32 bits: byte address.
REQ-010 Port data_wdata, input, 32 bits: write data, already lane-aligned by the master.
REQ-011 Port data_rdata, output, 32 bits: full read word.
REQ-012 Port data_addr_ok, output, 1 bit: address handshake.
REQ-013 Port data_data_ok, output, 1 bit: data/completion handshake, a one-cycle pulse.

Function
REQ-014 The block SHALL have three states:
  - IDLE: accepting requests.
  - BUSY: latency countdown.
  - RESP: data_data_ok cycle.
REQ-015 IDLE timing:
  - A wait counter SHALL increment on each cycle with data_req=1 and counter<ADDR_DELAY.
  - data_addr_ok SHALL be asserted combinationally when state=IDLE, data_req=1 and counter==ADDR_DELAY.
  - With ADDR_DELAY=0, data_addr_ok SHALL assert in the same cycle as data_req.
REQ-016 If data_req drops in IDLE before the handshake, the wait counter SHALL clear to 0 and nothing is recorded.
REQ-017 Handshake cycle (data_req & data_addr_ok):
  - The block SHALL latch data_wr, data_size, data_addr[1:0] and the word index data_addr[AW+1:2].
  - The block SHALL go to BUSY with the latency counter at DATA_LATENCY-1.
  - Upper address bits above AW+1 SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-018 A write SHALL commit at the handshake clock edge using the byte strobe:
  - Byte: strobe = 0001 shifted left by addr[1:0].
  - Halfword: 0011 if addr[1]=0, 1100 if addr[1]=1; addr[0] is ignored.
  - Word: 1111; addr[1:0] are ignored.
REQ-019 Only the strobed lanes of data_wdata SHALL be written; all other bytes keep their value.
REQ-020 A read SHALL capture the addressed word, as it is after any earlier commits, into the response register at the handshake edge.
REQ-021 BUSY SHALL decrement the latency counter each cycle and move to RESP when the counter is 0.
  - With DATA_LATENCY=1, RESP is the cycle right after the handshake.
REQ-022 RESP SHALL assert data_data_ok for exactly one cycle, then return to IDLE with the wait counter at 0.
REQ-023 data_rdata SHALL present the response register. It is valid during the data_data_ok cycle for reads and holds its value until the next read handshake.
  - For writes, data_rdata SHALL be left unchanged.
REQ-024 At most one transaction SHALL be outstanding: data_addr_ok SHALL be 0 in BUSY and RESP, whatever data_req is.
REQ-025 Inputs other than data_req SHALL be don't-care outside the handshake cycle.
REQ-026 A request held high through RESP SHALL be handled as a fresh IDLE request from the next cycle, including the full ADDR_DELAY wait.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the wait counter, the latency counter and the latched request fields.
REQ-028 While rst=1, data_addr_ok and data_data_ok SHALL be 0; after reset data_rdata SHALL be 32'h0.
REQ-029 Reset during BUSY or RESP SHALL abort the transaction with no data_data_ok.
  - A write already committed at its handshake SHALL stay in memory.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 A shared package SHALL hold:
  - the state enumeration (IDLE, BUSY, RESP);
  - the size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - the strobe-generation function.
REQ-032 The storage array SHALL be a sub-module sramlike_bank: DEPTH x 32 bits, 4-bit byte write enable, synchronous read into a register.
  - The handshake and timing logic SHALL stay in data_sramlike_slave.

Verification
REQ-033 Word write then read, with ADDR_DELAY=0, DATA_LATENCY=1:
  - Stimulus: write 0xDEADBEEF to 0x100, then read 0x100.
  - Response: addr_ok in the request cycle, data_ok one cycle later, read data 0xDEADBEEF.
REQ-034 Byte write lanes:
  - Stimulus: word 0x11223344 at 0x200, then byte write of 0x0000AB00 at 0x201.
  - Response: a read of 0x200 returns 0x1122AB44.
REQ-035 Halfword write:
  - Stimulus: after REQ-034, halfword write of 0xCDEF0000 at 0x202.
  - Response: a read returns 0xCDEFAB44.
REQ-036 Timing with ADDR_DELAY=3, DATA_LATENCY=4:
  - Stimulus: a held request.
  - Response: addr_ok in the 4th request cycle, data_ok 4 cycles after the handshake, exactly one pulse.
  - Stimulus: data_req dropped after 2 cycles and reasserted.
  - Response: the wait restarts from 0.
REQ-037 Reset mid-operation:
  - Stimulus: rst pulsed in BUSY after a write of 0x5A5A5A5A to 0x300.
  - Response: no data_ok; a later read of 0x300 returns 0x5A5A5A5A.
  - Stimulus: addresses 0x0 and DEPTH*4 used for the same data.
  - Response: both alias to the same word.
